dig_core_echo: RTL and testbench

- Digital core of the waveform generator's host link.
- Receives 8N1 UART bytes on rx_i and answers each valid byte by transmitting its bitwise complement on tx_o.
- Mirrors the last valid received byte on debug_o for board LEDs/probing.
- Sits between the board UART pins and later command-decoding logic.
- Single clock domain; rx_i is the only asynchronous input.

---
 rtl/dig_core_pkg.sv | 22 ++
 rtl/dig_core_uart.sv | 209 ++++++++++++++++++++
 rtl/dig_core_echo.sv | 64 ++++++
 tb/tb_dig_core_echo.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dig_core_pkg.sv
// Shared constants and state encodings for the host-link UART echo core.
package dig_core_pkg;

  localparam int DIVISOR_DEF   = 326;
  localparam int DATA_BITS_DEF = 8;
  localparam int OVERSAMPLE    = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/dig_core_uart.sv
// 8N1 UART with 16x oversampling: shared tick, rx synchronizer, RX and TX FSMs.
// RX byte valid is a 1-clock pulse after mid-stop; TX accepts a byte when idle or on its final stop tick.
module dig_core_uart
  import dig_core_pkg::*;
#(
  parameter int DIVISOR   = DIVISOR_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic                 o_tx,
  output logic                 o_rx_vld,
  output logic [DATA_BITS-1:0] o_rx_dat,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_dat,
  output logic                 o_tx_idle,
  output logic                 o_tx_last
);

  localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [1:0]       r_sync;
  logic             r_rx_prev;
  logic             w_rx;
  logic             w_fall;

  rx_state_t              r_rx_st;
  logic [OS_W-1:0]        r_rx_tick;
  logic [BIT_W-1:0]       r_rx_bit;
  logic [DATA_BITS-1:0]   r_rx_shift;
  logic                   r_rx_ferr;
  logic                   r_rx_vld;
  logic [DATA_BITS-1:0]   r_rx_dat;

  tx_state_t              r_tx_st;
  logic [OS_W-1:0]        r_tx_tick;
  logic [BIT_W-1:0]       r_tx_bit;
  logic [DATA_BITS-1:0]   r_tx_shift;
  logic                   r_tx;

  assign w_tick = (r_div == DIV_LAST);
  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_prev & ~w_rx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_div     <= w_tick ? '0 : r_div + 1'b1;
      r_sync    <= {r_sync[0], i_rx};
      r_rx_prev <= w_rx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_st    <= RX_IDLE;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_ferr  <= 1'b0;
      r_rx_vld   <= 1'b0;
      r_rx_dat   <= '0;
    end else begin
      r_rx_vld <= 1'b0;
      case (r_rx_st)
        RX_IDLE: begin
          if (w_fall) begin
            r_rx_st   <= RX_START;
            r_rx_tick <= '0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_tick == OS_HALF) begin
              r_rx_tick <= '0;
              r_rx_bit  <= '0;
              r_rx_st   <= w_rx ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_tick <= r_rx_tick + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rx_tick == OS_LAST) begin
              r_rx_tick  <= '0;
              r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
              if (r_rx_bit == BIT_LAST) r_rx_st <= RX_STOP;
              else r_rx_bit <= r_rx_bit + 1'b1;
            end else begin
              r_rx_tick <= r_rx_tick + 1'b1;
            end
          end
        end
        RX_STOP: begin
          // A framing error parks here until the line idles high again.
          if (r_rx_ferr) begin
            if (w_rx) begin
              r_rx_ferr <= 1'b0;
              r_rx_st   <= RX_IDLE;
            end
          end else if (w_tick) begin
            if (r_rx_tick == OS_LAST) begin
              r_rx_tick <= '0;
              if (w_rx) begin
                r_rx_vld <= 1'b1;
                r_rx_dat <= r_rx_shift;
                r_rx_st  <= RX_IDLE;
              end else begin
                r_rx_ferr <= 1'b1;
              end
            end else begin
              r_rx_tick <= r_rx_tick + 1'b1;
            end
          end
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  assign o_tx_idle = (r_tx_st == TX_IDLE);
  assign o_tx_last = (r_tx_st == TX_STOP) && w_tick && (r_tx_tick == OS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st    <= TX_IDLE;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_st)
        TX_IDLE: begin
          if (i_tx_start) begin
            r_tx_st    <= TX_START;
            r_tx_shift <= i_tx_dat;
            r_tx_tick  <= '0;
            r_tx       <= 1'b0;
          end
        end
        TX_START: begin
          if (w_tick) begin
            if (r_tx_tick == OS_LAST) begin
              r_tx_tick <= '0;
              r_tx_bit  <= '0;
              r_tx      <= r_tx_shift[0];
              r_tx_st   <= TX_DATA;
            end else begin
              r_tx_tick <= r_tx_tick + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_tx_tick == OS_LAST) begin
              r_tx_tick <= '0;
              if (r_tx_bit == BIT_LAST) begin
                r_tx_st <= TX_STOP;
                r_tx    <= 1'b1;
              end else begin
                r_tx_bit   <= r_tx_bit + 1'b1;
                r_tx_shift <= r_tx_shift >> 1;
                r_tx       <= r_tx_shift[1];
              end
            end else begin
              r_tx_tick <= r_tx_tick + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (r_tx_tick == OS_LAST) begin
              r_tx_tick <= '0;
              // Chain straight into the next frame when a byte is offered.
              if (i_tx_start) begin
                r_tx_st    <= TX_START;
                r_tx_shift <= i_tx_dat;
                r_tx       <= 1'b0;
              end else begin
                r_tx_st <= TX_IDLE;
              end
            end else begin
              r_tx_tick <= r_tx_tick + 1'b1;
            end
          end
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  assign o_tx     = r_tx;
  assign o_rx_vld = r_rx_vld;
  assign o_rx_dat = r_rx_dat;

endmodule

// File: rtl/dig_core_echo.sv
// Host-link echo: each valid received byte is mirrored on debug_o and echoed complemented.
// Echo start is 1 clock after rx valid when TX is idle; while TX is busy a 1-entry pending slot holds the newest echo.
module dig_core_echo
  import dig_core_pkg::*;
#(
  parameter int DIVISOR   = DIVISOR_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic                 tx_o,
  output logic [DATA_BITS-1:0] debug_o
);

  logic                 w_rx_vld;
  logic [DATA_BITS-1:0] w_rx_dat;
  logic                 w_tx_idle;
  logic                 w_tx_last;
  logic                 w_tx_start;
  logic [DATA_BITS-1:0] w_tx_dat;
  logic                 r_pend_vld;
  logic [DATA_BITS-1:0] r_pend_dat;
  logic [DATA_BITS-1:0] r_debug;

  dig_core_uart #(
    .DIVISOR  (DIVISOR),
    .DATA_BITS(DATA_BITS)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (rx_i),
    .o_tx      (tx_o),
    .o_rx_vld  (w_rx_vld),
    .o_rx_dat  (w_rx_dat),
    .i_tx_start(w_tx_start),
    .i_tx_dat  (w_tx_dat),
    .o_tx_idle (w_tx_idle),
    .o_tx_last (w_tx_last)
  );

  // The pending byte is always older than a same-cycle arrival, so it goes first.
  assign w_tx_start = (w_tx_idle | w_tx_last) & (r_pend_vld | w_rx_vld);
  assign w_tx_dat   = r_pend_vld ? r_pend_dat : ~w_rx_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_dat <= '0;
      r_debug    <= '0;
    end else begin
      if (w_rx_vld) r_debug <= w_rx_dat;
      if (w_rx_vld && !(w_tx_start && !r_pend_vld)) begin
        r_pend_dat <= ~w_rx_dat;
        r_pend_vld <= 1'b1;
      end else if (w_tx_start) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign debug_o = r_debug;

endmodule

// File: tb/tb_dig_core_echo.sv
// Directed bench for dig_core_echo: a bench UART drives rx_i, a frame monitor decodes tx_o
// and checks each echo against a queue of expected complements.
module tb_dig_core_echo;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       tx_o;
  logic [7:0] debug_o;

  int         checks = 0;
  int         errors = 0;
  int         good_frames = 0;
  bit         mon_busy = 1'b0;
  bit         mon_abort;
  logic [9:0] mon_bits;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  dig_core_echo #(
    .DIVISOR  (DIV),
    .DATA_BITS(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx_i),
    .tx_o   (tx_o),
    .debug_o(debug_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      clks(BIT);
    end
    rx_i = stop_bit;
    clks(BIT);
    rx_i = 1'b1;
    if (stop_bit) exp_q.push_back(~b);
  endtask

  task automatic quiet_check(input string tag, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    chk(tag, lows, 0);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Frame monitor: samples each tx_o bit near its middle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && tx_o === 1'b0) begin
        mon_busy  = 1'b1;
        mon_abort = 1'b0;
        mon_bits  = '0;
        for (int c = 1; c <= BIT / 2 + 9 * BIT; c++) begin
          @(negedge clk);
          if (rst) mon_abort = 1'b1;
          if (c >= BIT / 2 && (c - BIT / 2) % BIT == 0) mon_bits[(c - BIT / 2) / BIT] = tx_o;
        end
        if (mon_abort) begin
          if (exp_q.size() > 0) exp_q.delete(0);
        end else begin
          chk("echo_start_bit", mon_bits[0], 1'b0);
          chk("echo_stop_bit", mon_bits[9], 1'b1);
          chk("echo_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            chk("echo_data", mon_bits[8:1], mon_exp);
          end
          good_frames++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    rst  = 1'b1;
    rx_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("reset_tx", tx_o, 1'b1);
      chk("reset_debug", debug_o, 8'h00);
    end
    rst = 1'b0;
    quiet_check("idle_after_reset", 1000);

    send_byte(8'hA1, 1'b1);
    chk("single_debug", debug_o, 8'hA1);
    drain("single_echo_drain");

    send_byte(8'hA1, 1'b1);
    chk("b2b_debug0", debug_o, 8'hA1);
    send_byte(8'h00, 1'b1);
    chk("b2b_debug1", debug_o, 8'h00);
    send_byte(8'h01, 1'b1);
    chk("b2b_debug2", debug_o, 8'h01);
    drain("b2b_drain");

    send_byte(8'h3C, 1'b0);
    clks(BIT);
    chk("ferr_debug", debug_o, 8'h01);
    quiet_check("ferr_no_echo", 700);
    send_byte(8'h55, 1'b1);
    chk("after_ferr_debug", debug_o, 8'h55);
    drain("after_ferr_drain");

    rx_i = 1'b0;
    clks(20);
    rx_i = 1'b1;
    quiet_check("glitch_quiet", 800);
    chk("glitch_debug", debug_o, 8'h55);
    chk("glitch_frames", good_frames, 5);

    // Echo of 8'h08 is 8'hF7, whose bit 3 is the only low data bit.
    send_byte(8'h08, 1'b1);
    clks(260);
    chk("pre_rst_bit3_low", tx_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx_high", tx_o, 1'b1);
    chk("rst_mid_debug", debug_o, 8'h00);
    clks(2);
    rst = 1'b0;
    quiet_check("no_bits_after_rst", 700);

    send_byte(8'h0F, 1'b1);
    chk("post_rst_debug", debug_o, 8'h0F);
    drain("post_rst_drain");
    chk("total_good_frames", good_frames, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
